// File: rtl/mips_bus_pkg.sv
// ---------------------------------------------------------------------------
// mips_bus_pkg
//   Shared definitions for the CPU data-bus bridge:
//     - bus_state_e     : bridge FSM states (IDLE / REQ / DONE)
//     - DEF_EXT_BASE    : default base address of the external window
//     - DEF_EXT_MASK    : default decode mask of the external window
//     - DEF_ERR_DATA    : default read data returned on a timed-out read
//     - ext_window_hit(): address decode for the external window
// ---------------------------------------------------------------------------
package mips_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } bus_state_e;

    localparam logic [31:0] DEF_EXT_BASE = 32'hFFFF_0000;
    localparam logic [31:0] DEF_EXT_MASK = 32'hFFFF_0000;
    localparam logic [31:0] DEF_ERR_DATA = 32'hDEAD_BEEF;

    // Decode is done at a fixed wide width so one function serves any
    // ADDR_W up to 64; callers zero-extend their operands.
    localparam int DECODE_W = 64;

    function automatic logic ext_window_hit(
        input logic [DECODE_W-1:0] addr,
        input logic [DECODE_W-1:0] base,
        input logic [DECODE_W-1:0] mask
    );
        return (addr & mask) == base;
    endfunction

endpackage

// File: rtl/bus_timeout_counter.sv
// ---------------------------------------------------------------------------
// bus_timeout_counter
//   Counts enabled cycles since the last clear and flags the cycle that is
//   the LIMIT-th enabled cycle, so the owner can abort in that same cycle.
//
//   Ports:
//     clk     in  system clock
//     rst     in  synchronous active-low reset
//     clear   in  restart the count at zero
//     enable  in  count this cycle
//     expired out this enabled cycle is the LIMIT-th one since clear
// ---------------------------------------------------------------------------
module bus_timeout_counter #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(LIMIT + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);
    localparam logic [CNT_W-1:0] MAXV = CNT_W'(LIMIT);

    logic [CNT_W-1:0] count_q;

    // Saturates at LIMIT; the owner leaves the counting state on expiry so
    // the saturation only guards against misuse.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (enable && (count_q != MAXV)) begin
            count_q <= count_q + 1'b1;
        end
    end

    // count_q holds the number of enabled cycles already completed, so the
    // current cycle is number count_q+1.
    assign expired = enable && (count_q == LAST);

endmodule

// File: rtl/mips_dbus_bridge.sv
// ---------------------------------------------------------------------------
// mips_dbus_bridge
//   Routes CPU data accesses either to the internal dual-port memory
//   (zero-wait pass-through) or to an external bus window with a
//   request/ready handshake, CPU stall, wait-state timeout and error report.
//
//   Ports:
//     clk, rst                    clock, synchronous active-low reset
//     cpu_read_en/cpu_write_en    CPU access request (both => write)
//     cpu_addr, cpu_write_data    CPU address / store data
//     cpu_read_data, cpu_stall    load data / pipeline hold
//     mem_*                       internal memory port (combinational)
//     ext_read_en/ext_write_en    registered external strobes, held to ready
//     ext_addr, ext_write_data    registered external address / data
//     ext_data_in, ext_ready      external read data / completion
//     bus_error                   one-cycle pulse on timeout
//     bus_error_sticky            set on any timeout, cleared by reset only
// ---------------------------------------------------------------------------
module mips_dbus_bridge
    import mips_bus_pkg::*;
#(
    parameter int                DATA_W   = 32,
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] EXT_BASE = ADDR_W'(DEF_EXT_BASE),
    parameter logic [ADDR_W-1:0] EXT_MASK = ADDR_W'(DEF_EXT_MASK),
    parameter int                TIMEOUT  = 255,
    parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(DEF_ERR_DATA)
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              cpu_read_en,
    input  logic              cpu_write_en,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_write_data,
    output logic [DATA_W-1:0] cpu_read_data,
    output logic              cpu_stall,

    output logic              mem_read_en,
    output logic              mem_write_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic [DATA_W-1:0] mem_read_data,

    output logic              ext_read_en,
    output logic              ext_write_en,
    output logic [ADDR_W-1:0] ext_addr,
    output logic [DATA_W-1:0] ext_write_data,
    input  logic [DATA_W-1:0] ext_data_in,
    input  logic              ext_ready,

    output logic              bus_error,
    output logic              bus_error_sticky
);

    bus_state_e        state_q, state_d;
    logic              dir_wr_q;     // latched direction: 1 = write
    logic [DATA_W-1:0] rdata_q;      // data handed to the CPU in DONE
    logic              tmo_expired;

    logic cpu_access;
    logic cpu_rd_only;
    logic is_ext;

    assign cpu_access  = cpu_read_en | cpu_write_en;
    assign cpu_rd_only = cpu_read_en & ~cpu_write_en;
    assign is_ext      = ext_window_hit(DECODE_W'(cpu_addr),
                                        DECODE_W'(EXT_BASE),
                                        DECODE_W'(EXT_MASK));

    // Address and store data always track the CPU; only the enables are
    // qualified, so the memory never sees a stray strobe.
    assign mem_addr       = cpu_addr;
    assign mem_write_data = cpu_write_data;

    // Counter restarts while idle, so each transaction gets a full window.
    bus_timeout_counter #(
        .LIMIT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (state_q == IDLE),
        .enable  (state_q == REQ),
        .expired (tmo_expired)
    );

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- next state / combinational outputs ----------------
    always_comb begin
        state_d       = state_q;
        cpu_stall     = 1'b0;
        cpu_read_data = '0;
        mem_read_en   = 1'b0;
        mem_write_en  = 1'b0;

        case (state_q)
            IDLE: begin
                if (cpu_access && is_ext) begin
                    cpu_stall = 1'b1;
                    state_d   = REQ;
                end else begin
                    mem_read_en  = cpu_rd_only;
                    mem_write_en = cpu_write_en;
                    if (cpu_rd_only) begin
                        cpu_read_data = mem_read_data;
                    end
                end
            end
            REQ: begin
                cpu_stall = 1'b1;
                // Ready takes priority over an expiry in the same cycle.
                if (ext_ready || tmo_expired) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                // The stale request is still on the CPU port; ignore it.
                cpu_read_data = dir_wr_q ? '0 : rdata_q;
                state_d       = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ---------------- external bus datapath ----------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            ext_read_en      <= 1'b0;
            ext_write_en     <= 1'b0;
            ext_addr         <= '0;
            ext_write_data   <= '0;
            dir_wr_q         <= 1'b0;
            rdata_q          <= '0;
            bus_error        <= 1'b0;
            bus_error_sticky <= 1'b0;
        end else begin
            bus_error <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cpu_access && is_ext) begin
                        ext_addr       <= cpu_addr;
                        ext_write_data <= cpu_write_data;
                        dir_wr_q       <= cpu_write_en;
                        ext_write_en   <= cpu_write_en;
                        ext_read_en    <= ~cpu_write_en;
                    end
                end
                REQ: begin
                    if (ext_ready) begin
                        ext_read_en  <= 1'b0;
                        ext_write_en <= 1'b0;
                        rdata_q      <= ext_data_in;
                    end else if (tmo_expired) begin
                        ext_read_en      <= 1'b0;
                        ext_write_en     <= 1'b0;
                        rdata_q          <= ERR_DATA;
                        bus_error        <= 1'b1;
                        bus_error_sticky <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips_dbus_bridge.sv
module tb_mips_dbus_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_read_en, cpu_write_en;
    logic [31:0] cpu_addr, cpu_write_data, cpu_read_data;
    logic        cpu_stall;
    logic        mem_read_en, mem_write_en;
    logic [31:0] mem_addr, mem_write_data, mem_read_data;
    logic        ext_read_en, ext_write_en;
    logic [31:0] ext_addr, ext_write_data, ext_data_in;
    logic        ext_ready;
    logic        bus_error, bus_error_sticky;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mips_dbus_bridge #(
        .DATA_W (32),
        .ADDR_W (32),
        .TIMEOUT(4)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .cpu_read_en      (cpu_read_en),
        .cpu_write_en     (cpu_write_en),
        .cpu_addr         (cpu_addr),
        .cpu_write_data   (cpu_write_data),
        .cpu_read_data    (cpu_read_data),
        .cpu_stall        (cpu_stall),
        .mem_read_en      (mem_read_en),
        .mem_write_en     (mem_write_en),
        .mem_addr         (mem_addr),
        .mem_write_data   (mem_write_data),
        .mem_read_data    (mem_read_data),
        .ext_read_en      (ext_read_en),
        .ext_write_en     (ext_write_en),
        .ext_addr         (ext_addr),
        .ext_write_data   (ext_write_data),
        .ext_data_in      (ext_data_in),
        .ext_ready        (ext_ready),
        .bus_error        (bus_error),
        .bus_error_sticky (bus_error_sticky)
    );

    typedef struct {
        logic        rd, wr;
        logic [31:0] addr, wdata, mrd;
        logic        rdy;
        logic [31:0] edin;
        logic        stall;
        logic [31:0] crd;
        logic        mre, mwe, erd, ewr;
        logic [31:0] eaddr, ewd;
        logic        err;
    } vec_t;

    localparam int NV = 14;
    vec_t tbl [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drv(input logic r, input logic rd, input logic wr,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] mrd, input logic rdy, input logic [31:0] ed);
        rst            = r;
        cpu_read_en    = rd;
        cpu_write_en   = wr;
        cpu_addr       = a;
        cpu_write_data = wd;
        mem_read_data  = mrd;
        ext_ready      = rdy;
        ext_data_in    = ed;
    endtask

    // Inputs change 1 time unit after the rising edge; checks happen at the
    // falling edge, well away from either edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //            rd wr addr           wdata          mrd            rdy edin           stall crd            mre mwe erd ewr eaddr          ewd            err
        // internal read / write / read+write / idle
        tbl[0]  = '{1, 0, 32'h0000_0040, 32'h0,         32'h1234_5678, 0, 32'h0,         0, 32'h1234_5678, 1, 0, 0, 0, 32'h0,         32'h0,         0};
        tbl[1]  = '{0, 1, 32'h0000_0044, 32'h1111_2222, 32'h0,         0, 32'h0,         0, 32'h0,         0, 1, 0, 0, 32'h0,         32'h0,         0};
        tbl[2]  = '{1, 1, 32'h0000_0048, 32'h3333_4444, 32'h5555_6666, 0, 32'h0,         0, 32'h0,         0, 1, 0, 0, 32'h0,         32'h0,         0};
        tbl[3]  = '{0, 0, 32'h0000_0048, 32'h0,         32'h5555_6666, 0, 32'h0,         0, 32'h0,         0, 0, 0, 0, 32'h0,         32'h0,         0};
        // external read, ready in 3rd REQ cycle: IDLE, REQ1..3, DONE, IDLE
        tbl[4]  = '{1, 0, 32'hFFFF_0004, 32'h0,         32'h0,         0, 32'h0,         1, 32'h0,         0, 0, 0, 0, 32'h0,         32'h0,         0};
        tbl[5]  = '{1, 0, 32'hFFFF_0004, 32'h0,         32'h0,         0, 32'h0,         1, 32'h0,         0, 0, 1, 0, 32'hFFFF_0004, 32'h0,         0};
        tbl[6]  = '{1, 0, 32'hFFFF_0004, 32'h0,         32'h0,         0, 32'h0,         1, 32'h0,         0, 0, 1, 0, 32'hFFFF_0004, 32'h0,         0};
        tbl[7]  = '{1, 0, 32'hFFFF_0004, 32'h0,         32'h0,         1, 32'hCAFE_0001, 1, 32'h0,         0, 0, 1, 0, 32'hFFFF_0004, 32'h0,         0};
        tbl[8]  = '{1, 0, 32'hFFFF_0004, 32'h0,         32'h0,         0, 32'h0,         0, 32'hCAFE_0001, 0, 0, 0, 0, 32'hFFFF_0004, 32'h0,         0};
        tbl[9]  = '{0, 0, 32'h0000_0000, 32'h0,         32'h0,         0, 32'h0,         0, 32'h0,         0, 0, 0, 0, 32'hFFFF_0004, 32'h0,         0};
        // external write, ready in 1st REQ cycle: IDLE, REQ1, DONE, IDLE
        tbl[10] = '{0, 1, 32'hFFFF_0008, 32'hA5A5_A5A5, 32'h0,         0, 32'h0,         1, 32'h0,         0, 0, 0, 0, 32'hFFFF_0004, 32'h0,         0};
        tbl[11] = '{0, 1, 32'hFFFF_0008, 32'hA5A5_A5A5, 32'h0,         1, 32'h0,         1, 32'h0,         0, 0, 0, 1, 32'hFFFF_0008, 32'hA5A5_A5A5, 0};
        tbl[12] = '{0, 1, 32'hFFFF_0008, 32'hA5A5_A5A5, 32'h0,         0, 32'h0,         0, 32'h0,         0, 0, 0, 0, 32'hFFFF_0008, 32'hA5A5_A5A5, 0};
        tbl[13] = '{0, 0, 32'h0000_0000, 32'h0,         32'h0,         0, 32'h0,         0, 32'h0,         0, 0, 0, 0, 32'hFFFF_0008, 32'hA5A5_A5A5, 0};

        // ---------------- reset held 3 cycles with an external read pending
        drv(0, 1, 0, 32'hFFFF_0010, 32'h0, 32'h0, 0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            #4;
            chk($sformatf("rst%0d.ext_rd", i), ext_read_en, 1'b0);
            chk($sformatf("rst%0d.ext_wr", i), ext_write_en, 1'b0);
            chk($sformatf("rst%0d.err", i), bus_error, 1'b0);
            chk($sformatf("rst%0d.sticky", i), bus_error_sticky, 1'b0);
        end
        chk("rst.state", dut.state_q, mips_bus_pkg::IDLE);
        next_cycle();

        // ---------------- table-driven cycle vectors
        for (int i = 0; i < NV; i++) begin
            drv(1, tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].mrd, tbl[i].rdy, tbl[i].edin);
            #4;
            chk($sformatf("v%0d.stall", i), cpu_stall, tbl[i].stall);
            chk($sformatf("v%0d.rdata", i), cpu_read_data, tbl[i].crd);
            chk($sformatf("v%0d.mem_rd", i), mem_read_en, tbl[i].mre);
            chk($sformatf("v%0d.mem_wr", i), mem_write_en, tbl[i].mwe);
            chk($sformatf("v%0d.mem_addr", i), mem_addr, tbl[i].addr);
            chk($sformatf("v%0d.mem_wdata", i), mem_write_data, tbl[i].wdata);
            chk($sformatf("v%0d.ext_rd", i), ext_read_en, tbl[i].erd);
            chk($sformatf("v%0d.ext_wr", i), ext_write_en, tbl[i].ewr);
            chk($sformatf("v%0d.ext_addr", i), ext_addr, tbl[i].eaddr);
            chk($sformatf("v%0d.ext_wdata", i), ext_write_data, tbl[i].ewd);
            chk($sformatf("v%0d.err", i), bus_error, tbl[i].err);
            next_cycle();
        end

        // ---------------- timeout (TIMEOUT=4), ready never arrives
        drv(1, 1, 0, 32'hFFFF_0000, 32'h0, 32'h0, 0, 32'h0);
        #4; chk("to.idle.stall", cpu_stall, 1'b1);
        next_cycle();
        for (int k = 1; k <= 4; k++) begin
            #4;
            chk($sformatf("to.req%0d.ext_rd", k), ext_read_en, 1'b1);
            chk($sformatf("to.req%0d.stall", k), cpu_stall, 1'b1);
            chk($sformatf("to.req%0d.err", k), bus_error, 1'b0);
            next_cycle();
        end
        #4;
        chk("to.done.rdata", cpu_read_data, 32'hDEAD_BEEF);
        chk("to.done.stall", cpu_stall, 1'b0);
        chk("to.done.ext_rd", ext_read_en, 1'b0);
        chk("to.done.err", bus_error, 1'b1);
        chk("to.done.sticky", bus_error_sticky, 1'b1);
        next_cycle();
        drv(1, 0, 0, 32'h0, 32'h0, 32'h0, 0, 32'h0);
        #4;
        chk("to.after.err", bus_error, 1'b0);
        chk("to.after.sticky", bus_error_sticky, 1'b1);
        next_cycle();

        // ---------------- normal access after a timeout
        drv(1, 1, 0, 32'hFFFF_0020, 32'h0, 32'h0, 0, 32'h0);
        #4; chk("post.idle.stall", cpu_stall, 1'b1);
        next_cycle();
        drv(1, 1, 0, 32'hFFFF_0020, 32'h0, 32'h0, 1, 32'h0BAD_F00D);
        #4; chk("post.req.ext_rd", ext_read_en, 1'b1);
        chk("post.req.ext_addr", ext_addr, 32'hFFFF_0020);
        next_cycle();
        drv(1, 1, 0, 32'hFFFF_0020, 32'h0, 32'h0, 0, 32'h0);
        #4;
        chk("post.done.rdata", cpu_read_data, 32'h0BAD_F00D);
        chk("post.done.err", bus_error, 1'b0);
        chk("post.done.sticky", bus_error_sticky, 1'b1);
        chk("post.done.stall", cpu_stall, 1'b0);
        next_cycle();
        drv(1, 0, 0, 32'h0, 32'h0, 32'h0, 0, 32'h0);
        next_cycle();

        // ---------------- ready arrives on the expiry cycle: ready wins
        drv(1, 1, 0, 32'hFFFF_000C, 32'h0, 32'h0, 0, 32'h0);
        next_cycle();
        for (int k = 1; k <= 4; k++) begin
            if (k == 4) drv(1, 1, 0, 32'hFFFF_000C, 32'h0, 32'h0, 1, 32'h1357_9BDF);
            #4;
            chk($sformatf("exp.req%0d.stall", k), cpu_stall, 1'b1);
            next_cycle();
        end
        drv(1, 1, 0, 32'hFFFF_000C, 32'h0, 32'h0, 0, 32'h0);
        #4;
        chk("exp.done.rdata", cpu_read_data, 32'h1357_9BDF);
        chk("exp.done.err", bus_error, 1'b0);
        next_cycle();
        drv(1, 0, 0, 32'h0, 32'h0, 32'h0, 0, 32'h0);
        #4; chk("exp.after.err", bus_error, 1'b0);
        next_cycle();

        // ---------------- reset in the 2nd REQ cycle
        drv(1, 1, 0, 32'hFFFF_0014, 32'h0, 32'h0, 0, 32'h0);
        next_cycle();
        #4; chk("mid.req1.ext_rd", ext_read_en, 1'b1);
        next_cycle();
        drv(0, 1, 0, 32'hFFFF_0014, 32'h0, 32'h0, 0, 32'h0);
        #4; chk("mid.req2.ext_rd", ext_read_en, 1'b1);
        next_cycle();
        drv(1, 0, 0, 32'h0, 32'h0, 32'h0, 0, 32'h0);
        #4;
        chk("mid.after.ext_rd", ext_read_en, 1'b0);
        chk("mid.after.stall", cpu_stall, 1'b0);
        chk("mid.after.sticky", bus_error_sticky, 1'b0);
        chk("mid.after.ext_addr", ext_addr, 32'h0);
        chk("mid.after.state", dut.state_q, mips_bus_pkg::IDLE);
        next_cycle();
        // fresh write from IDLE
        drv(1, 0, 1, 32'hFFFF_0018, 32'h2468_ACE0, 32'h0, 0, 32'h0);
        #4;
        chk("new.idle.stall", cpu_stall, 1'b1);
        chk("new.idle.ext_wr", ext_write_en, 1'b0);
        next_cycle();
        drv(1, 0, 1, 32'hFFFF_0018, 32'h2468_ACE0, 32'h0, 1, 32'h0);
        #4;
        chk("new.req.ext_wr", ext_write_en, 1'b1);
        chk("new.req.ext_rd", ext_read_en, 1'b0);
        chk("new.req.ext_addr", ext_addr, 32'hFFFF_0018);
        chk("new.req.ext_wdata", ext_write_data, 32'h2468_ACE0);
        next_cycle();
        drv(1, 0, 1, 32'hFFFF_0018, 32'h2468_ACE0, 32'h0, 0, 32'h0);
        #4;
        chk("new.done.stall", cpu_stall, 1'b0);
        chk("new.done.ext_wr", ext_write_en, 1'b0);
        chk("new.done.rdata", cpu_read_data, 32'h0);
        chk("new.done.err", bus_error, 1'b0);
        next_cycle();
        drv(1, 0, 0, 32'h0, 32'h0, 32'h0, 0, 32'h0);
        next_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mips_dbus_bridge.md
Name: mips_dbus_bridge

Overview:
- Sits between the pipeline data port and the rest of the system.
- Decodes each CPU data access by address and routes it either to the internal dual-port memory (zero-wait pass-through) or to a parametrised external bus window.
- External accesses use a request/ready handshake with CPU stall generation, a wait-state timeout and error reporting.
- Replaces the fixed, unused ext_* tie-off at system level with a working external bus.

Parameters:
- DATA_W, 32, data width of CPU, memory and external buses
- ADDR_W, 32, address width
- EXT_BASE, 32'hFFFF_0000, base address of the external window
- EXT_MASK, 32'hFFFF_0000, decode mask; access is external iff (cpu_addr & EXT_MASK) == EXT_BASE
- TIMEOUT, 255, max wait cycles for ext_ready before abort; range 1..65535
- ERR_DATA, 32'hDEAD_BEEF, read data returned on a timed-out read

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-low reset
- cpu_read_en  in  1  CPU data read request
- cpu_write_en  in  1  CPU data write request
- cpu_addr  in  ADDR_W  CPU data address
- cpu_write_data  in  DATA_W  CPU store data
- cpu_read_data  out  DATA_W  load data to CPU
- cpu_stall  out  1  hold pipeline; CPU keeps request stable while high
- mem_read_en  out  1  internal memory read enable
- mem_write_en  out  1  internal memory write enable
- mem_addr  out  ADDR_W  internal memory address
- mem_write_data  out  DATA_W  internal memory write data
- mem_read_data  in  DATA_W  internal memory read data
- ext_read_en  out  1  external read strobe, held until ready
- ext_write_en  out  1  external write strobe, held until ready
- ext_addr  out  ADDR_W  registered external address
- ext_write_data  out  DATA_W  registered external write data
- ext_data_in  in  DATA_W  external read data, valid with ext_ready
- ext_ready  in  1  external completion
- bus_error  out  1  one-cycle pulse on timeout
- bus_error_sticky  out  1  set on any timeout, cleared only by reset

Behaviour:
- Reset (rst==0 at an edge):
  - FSM goes to IDLE; timeout counter cleared.
  - ext_read_en, ext_write_en, ext_addr and ext_write_data go to 0.
  - bus_error and bus_error_sticky go to 0.
  - Reset mid-transaction abandons it; strobes are low from the next cycle.
- Internal access, in any state:
  - Applies only when the address does not decode to the external window.
  - mem_* = cpu_* combinationally; cpu_read_data = mem_read_data; no stall.
  - In REQ/DONE, mem_* enables are forced to 0.
- Read and write asserted together: treated as a write; cpu_read_data is 0.
- FSM states: IDLE, REQ, DONE.
- IDLE:
  - An external-decoded access raises cpu_stall combinationally in the same cycle.
  - Latches addr, data and direction; goes to REQ.
- REQ:
  - ext_*_en is registered from the latch; ext_addr and ext_write_data are stable throughout.
  - cpu_stall = 1.
  - Counter increments each REQ cycle.
  - ext_ready==1: capture ext_data_in into the read register; go to DONE.
  - Otherwise, when the counter reaches TIMEOUT: go to DONE; read register = ERR_DATA; pulse bus_error; set sticky.
  - ext_ready in the same cycle as expiry: ready wins, no error.
- DONE:
  - ext strobes low; cpu_stall = 0; cpu_read_data = read register (writes: 0).
  - CPU inputs are ignored (the old request is still visible); always returns to IDLE.
- Latency: ext_ready seen in the k-th REQ cycle gives k+1 stall cycles; data is delivered in the following DONE cycle.
- Back-to-back external accesses always pass through IDLE, so there is one idle bus cycle minimum between strobes.
- Timeout counter width: clog2(TIMEOUT+1); it does not wrap because it is cleared on REQ entry.

Decomposition:
- Shared package mips_bus_pkg holds:
  - the state enum (IDLE/REQ/DONE)
  - default EXT_BASE/EXT_MASK
  - ERR_DATA
  - an ext-window decode function
- One natural sub-module: bus_timeout_counter (clear, enable, parametrised limit, expired flag).

Test Plan:
- Reset: hold rst=0 for 3 cycles with cpu_read_en=1 to 32'hFFFF_0010 -> all ext strobes, bus_error and sticky are 0, FSM is IDLE.
- Internal access: read 32'h0000_0040 with mem_read_data=32'h1234_5678 -> cpu_read_data=32'h1234_5678 in the same cycle; cpu_stall never high; ext strobes low.
- External read, 3 wait states: read 32'hFFFF_0004; ext_ready high on the 3rd REQ cycle with ext_data_in=32'hCAFE_0001 -> 4 stall cycles; DONE returns 32'hCAFE_0001; ext_addr=32'hFFFF_0004 throughout.
- External write, immediate ready: write 32'hA5A5_A5A5 to 32'hFFFF_0008 with ext_ready=1 on the 1st REQ cycle -> ext_write_en high for exactly 1 cycle with ext_write_data=32'hA5A5_A5A5; 2 stall cycles.
- Timeout with TIMEOUT=4: read 32'hFFFF_0000 with ext_ready held 0 -> after 4 REQ cycles, DONE returns 32'hDEAD_BEEF; bus_error pulses once; sticky stays 1; a 2nd external access proceeds normally.
- Edge cases:
  - ext_ready arrives on the expiry cycle -> data returned, no error.
  - rst=0 asserted in the 2nd REQ cycle -> strobes drop the next cycle; the following access starts cleanly from IDLE.
